int_timer: RTL and testbench

INT_TIMER -- requirements
Module: int_timer

---
 rtl/int_timer.sv | 115 +++++++++++
 tb/tb_int_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/int_timer.sv
// Memory-mapped 32-bit down-counting timer with one-shot / auto-reload modes and a
// maskable level interrupt.
module int_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] preset_q, preset_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic        flag_q, flag_d;

    logic wr_ctrl, wr_preset, auto_reload;

    assign wr_ctrl     = we && (addr == 2'd0);
    assign wr_preset   = we && (addr == 2'd1);
    assign auto_reload = (mode_q == 2'b01);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        flag_d   = flag_q;

        unique case (state_q)
            StIdle: begin
                if (en_q) state_d = StLoad;
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // A preset of 0 lands here too, so it behaves like a preset of 1.
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = StInt;
                end
            end
            StInt: begin
                if (auto_reload) begin
                    flag_d  = 1'b0;
                    state_d = StLoad;
                end else begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Host writes come last so they override the FSM's EN clear and flag update.
        if (wr_ctrl) begin
            en_d   = din[0];
            mode_d = din[2:1];
            im_d   = din[3];
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = din;
            flag_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            preset_q <= '0;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        dout = '0;
        unique case (addr)
            2'd0:    dout = {28'd0, im_q, mode_q, en_q};
            2'd1:    dout = preset_q;
            2'd2:    dout = count_q;
            default: dout = '0;
        endcase
    end

    assign irq = flag_q & im_q;

endmodule

// File: tb/tb_int_timer.sv
// Directed self-checking bench for int_timer: one-shot, auto-reload, mask, disable,
// clear, preset 0 and asynchronous reset.
module tb_int_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks;
    int failures;

    int_timer dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Host write; the rising edge used is "E0" for the caller, returns 1 time unit after it.
    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        addr     = 2'd0;
        we       = 1'b0;
        din      = '0;
        #12;
        check_reg("rst_ctrl", 2'd0, 32'd0);
        check_reg("rst_preset", 2'd1, 32'd0);
        check_reg("rst_count", 2'd2, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Stays idle after reset release without an EN write.
        step(4);
        check_reg("idle_count", 2'd2, 32'd0);

        // One-shot: PRESET=3, CTRL=0x9.
        host_write(2'd1, 32'd3);
        host_write(2'd0, 32'h9);
        step(1);
        check_reg("os_count_e1", 2'd2, 32'd0);
        step(1);
        check_reg("os_count_e2", 2'd2, 32'd3);
        step(1);
        check_reg("os_count_e3", 2'd2, 32'd2);
        step(1);
        check_reg("os_count_e4", 2'd2, 32'd1);
        check("os_irq_e4", {31'd0, irq}, 32'd0);
        step(1);
        check_reg("os_count_e5", 2'd2, 32'd0);
        check("os_irq_e5", {31'd0, irq}, 32'd1);
        step(1);
        check_reg("os_ctrl_e6", 2'd0, 32'h8);
        check("os_irq_e6", {31'd0, irq}, 32'd1);
        step(3);
        check("os_irq_held", {31'd0, irq}, 32'd1);
        check_reg("os_count_held", 2'd2, 32'd0);

        // Clear via PRESET write, then ignored writes.
        host_write(2'd1, 32'd7);
        check("clr_irq", {31'd0, irq}, 32'd0);
        host_write(2'd2, 32'hDEAD_BEEF);
        host_write(2'd3, 32'h1234_5678);
        check_reg("ign_ctrl", 2'd0, 32'h8);
        check_reg("ign_preset", 2'd1, 32'd7);
        check_reg("ign_count", 2'd2, 32'd0);
        check_reg("ign_addr3", 2'd3, 32'd0);

        // Auto-reload: PRESET=3, CTRL=0xB; pulses after E5, E10, E15.
        host_write(2'd1, 32'd3);
        host_write(2'd0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
                  (k == 5 || k == 10 || k == 15) ? 32'd1 : 32'd0);
            if (k == 6) check_reg("ar_count_e6", 2'd2, 32'd0);
            if (k == 7) check_reg("ar_count_e7", 2'd2, 32'd3);
        end
        host_write(2'd0, 32'h0);
        step(8);
        check("ar_off_irq", {31'd0, irq}, 32'd0);

        // Mask: IM=0 keeps irq low; CTRL=0x8 later clears the latent flag.
        host_write(2'd1, 32'd2);
        host_write(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        check_reg("mask_ctrl", 2'd0, 32'd0);
        host_write(2'd0, 32'h8);
        check("mask_clr_irq0", {31'd0, irq}, 32'd0);
        step(2);
        check("mask_clr_irq2", {31'd0, irq}, 32'd0);

        // Disable mid-count with a PRESET write during CNT.
        host_write(2'd1, 32'd10);
        host_write(2'd0, 32'h9);
        step(4);
        check_reg("dis_count_e4", 2'd2, 32'd8);
        host_write(2'd1, 32'd20);
        check_reg("dis_count_e5", 2'd2, 32'd7);
        check_reg("dis_preset", 2'd1, 32'd20);
        step(1);
        check_reg("dis_count_e6", 2'd2, 32'd6);
        host_write(2'd0, 32'h0);
        check_reg("dis_count_e7", 2'd2, 32'd5);
        step(5);
        check_reg("dis_count_frozen", 2'd2, 32'd5);
        check("dis_irq", {31'd0, irq}, 32'd0);

        // PRESET=0 acts like PRESET=1: flag at E3.
        host_write(2'd1, 32'd0);
        host_write(2'd0, 32'h9);
        step(2);
        check_reg("p0_count_e2", 2'd2, 32'd0);
        check("p0_irq_e2", {31'd0, irq}, 32'd0);
        step(1);
        check("p0_irq_e3", {31'd0, irq}, 32'd1);
        host_write(2'd0, 32'h0);

        // Asynchronous reset mid-count.
        host_write(2'd1, 32'd10);
        host_write(2'd0, 32'hB);
        step(4);
        check_reg("ar_pre_count", 2'd2, 32'd8);
        #1;
        reset = 1'b0;
        #1;
        check_reg("arst_count", 2'd2, 32'd0);
        check_reg("arst_ctrl", 2'd0, 32'd0);
        check_reg("arst_preset", 2'd1, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(15);
        check("arst_post_irq", {31'd0, irq}, 32'd0);
        check_reg("arst_post_count", 2'd2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
